// File: rtl/gray_sequence_checker_if.sv
// Sample/result bundle between a Gray code source and gray_sequence_checker.
interface gray_sequence_checker_if;
  logic        gray_valid;
  logic [15:0] gray_in;
  logic [3:0]  num_bits;
  logic        clear_err;
  logic [15:0] bin_out;
  logic        bin_valid;
  logic        locked;
  logic        seq_err;
  logic [7:0]  err_count;

  modport master (
    output gray_valid, gray_in, num_bits, clear_err,
    input  bin_out, bin_valid, locked, seq_err, err_count
  );

  modport slave (
    input  gray_valid, gray_in, num_bits, clear_err,
    output bin_out, bin_valid, locked, seq_err, err_count
  );
endinterface

// File: rtl/gray_sequence_checker.sv
// Decodes W-bit Gray codes (W = num_bits+1) and tracks whether they form an
// ascending, wrapping sequence; breaks while locked are pulsed and counted.
//
// state       | meaning
// ST_UNLOCKED | no reference yet; next valid sample becomes prev
// ST_LOCKING  | have prev, waiting for one correct increment
// ST_LOCKED   | tracking; non-increment is a sequence break
module gray_sequence_checker (
  input  logic clk,
  input  logic rst,
  gray_sequence_checker_if.slave bus
);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_LOCKING  = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] prev_q, prev_d;
  logic [3:0]  nb_q, nb_d;
  logic [15:0] bin_q, bin_d;
  logic        bin_valid_q, bin_valid_d;
  logic        seq_err_q, seq_err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic [15:0] width_mask;
  logic [15:0] gray_m;
  logic [15:0] bin_dec;
  logic [15:0] next_val;
  logic        match;
  logic        width_chg;
  logic [1:0]  cur_state;
  logic        cnt_inc;

  assign width_mask = 16'hFFFF >> (4'd15 - bus.num_bits);
  assign gray_m     = bus.gray_in & width_mask;

  // Running XOR from the MSB down; masked-off bits are zero so bin_dec above W is 0.
  always_comb begin
    logic acc;
    acc     = 1'b0;
    bin_dec = '0;
    for (int i = 15; i >= 0; i--) begin
      acc        = acc ^ gray_m[i];
      bin_dec[i] = acc;
    end
  end

  assign next_val  = (prev_q + 16'd1) & width_mask;
  assign match     = (bin_dec == next_val);
  assign width_chg = (bus.num_bits != nb_q);
  assign cur_state = width_chg ? ST_UNLOCKED : state_q;

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    nb_d        = nb_q;
    bin_d       = bin_q;
    bin_valid_d = 1'b0;
    seq_err_d   = 1'b0;
    cnt_inc     = 1'b0;
    if (bus.gray_valid) begin
      bin_d       = bin_dec;
      bin_valid_d = 1'b1;
      prev_d      = bin_dec;
      nb_d        = bus.num_bits;
      case (cur_state)
        ST_UNLOCKED: state_d = ST_LOCKING;
        ST_LOCKING:  state_d = match ? ST_LOCKED : ST_LOCKING;
        ST_LOCKED: begin
          if (match) begin
            state_d = ST_LOCKED;
          end else begin
            state_d   = ST_LOCKING;
            seq_err_d = 1'b1;
            cnt_inc   = 1'b1;
          end
        end
        default: state_d = ST_UNLOCKED;
      endcase
    end
  end

  // Clear has priority over a coincident increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.clear_err) begin
      err_cnt_d = 8'd0;
    end else if (cnt_inc && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_UNLOCKED;
      prev_q      <= '0;
      nb_q        <= 4'd15;
      bin_q       <= '0;
      bin_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      nb_q        <= nb_d;
      bin_q       <= bin_d;
      bin_valid_q <= bin_valid_d;
      seq_err_q   <= seq_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.bin_out   = bin_q;
  assign bus.bin_valid = bin_valid_q;
  assign bus.locked    = (state_q == ST_LOCKED);
  assign bus.seq_err   = seq_err_q;
  assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_gray_sequence_checker.sv
// Table- and sequence-driven bench for gray_sequence_checker with an expected-result queue.
module tb_gray_sequence_checker;

  typedef struct {
    logic        valid;
    logic [15:0] gray;
    logic [3:0]  nb;
    logic        clr;
    logic [15:0] bin;
    logic        bv;
    logic        lck;
    logic        serr;
    logic [7:0]  cnt;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t exp_q[$];
  vec_t mon_e;

  gray_sequence_checker_if ifc ();

  gray_sequence_checker dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [15:0] g, input logic [3:0] nb,
                              input logic clr, input logic [15:0] bin, input logic bv,
                              input logic lck, input logic serr, input logic [7:0] cnt);
    vec_t r;
    r.valid = v; r.gray = g; r.nb = nb; r.clr = clr;
    r.bin = bin; r.bv = bv; r.lck = lck; r.serr = serr; r.cnt = cnt;
    return r;
  endfunction

  function automatic logic [15:0] g_of(input logic [15:0] v);
    return v ^ (v >> 1);
  endfunction

  task automatic step(input vec_t v);
    @(negedge clk);
    ifc.gray_valid = v.valid;
    ifc.gray_in    = v.gray;
    ifc.num_bits   = v.nb;
    ifc.clear_err  = v.clr;
    exp_q.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    ifc.gray_valid = 1'b0;
    ifc.clear_err  = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_bin_out"},   ifc.bin_out, 16'h0000);
    check({tag, "_bin_valid"}, 16'(ifc.bin_valid), 16'h0);
    check({tag, "_locked"},    16'(ifc.locked), 16'h0);
    check({tag, "_seq_err"},   16'(ifc.seq_err), 16'h0);
    check({tag, "_err_count"}, 16'(ifc.err_count), 16'h0);
  endtask

  // Output monitor: each driven cycle's result appears after the following rising edge.
  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("bin_out",   ifc.bin_out, mon_e.bin);
      check("bin_valid", 16'(ifc.bin_valid), 16'(mon_e.bv));
      check("locked",    16'(ifc.locked), 16'(mon_e.lck));
      check("seq_err",   16'(ifc.seq_err), 16'(mon_e.serr));
      check("err_count", 16'(ifc.err_count), 16'(mon_e.cnt));
    end
  end

  initial begin
    vec_t        tbl[17];
    logic [15:0] g1[17];
    logic [15:0] v;
    logic [7:0]  sat;

    tbl[0]  = mk(1, 16'h0000, 3, 0, 16'd0, 1, 0, 0, 8'd0);
    tbl[1]  = mk(1, 16'h0001, 3, 0, 16'd1, 1, 1, 0, 8'd0);
    tbl[2]  = mk(1, 16'h0003, 3, 0, 16'd2, 1, 1, 0, 8'd0);
    tbl[3]  = mk(1, 16'h0007, 3, 0, 16'd5, 1, 0, 1, 8'd1);
    tbl[4]  = mk(1, 16'h0005, 3, 0, 16'd6, 1, 1, 0, 8'd1);
    tbl[5]  = mk(0, 16'h0000, 3, 0, 16'd6, 0, 1, 0, 8'd1);
    tbl[6]  = mk(1, 16'hFFF2, 1, 0, 16'h0003, 1, 0, 0, 8'd1);
    tbl[7]  = mk(1, 16'h0003, 1, 0, 16'h0002, 1, 0, 0, 8'd1);
    tbl[8]  = mk(1, 16'h0002, 1, 0, 16'h0003, 1, 1, 0, 8'd1);
    tbl[9]  = mk(1, 16'h0000, 1, 0, 16'h0000, 1, 1, 0, 8'd1);
    tbl[10] = mk(1, 16'h0000, 0, 0, 16'd0, 1, 0, 0, 8'd1);
    tbl[11] = mk(1, 16'h0001, 0, 0, 16'd1, 1, 1, 0, 8'd1);
    tbl[12] = mk(1, 16'h0000, 0, 0, 16'd0, 1, 1, 0, 8'd1);
    tbl[13] = mk(1, 16'h0000, 0, 0, 16'd0, 1, 0, 1, 8'd2);
    tbl[14] = mk(1, 16'h0001, 0, 0, 16'd1, 1, 1, 0, 8'd2);
    tbl[15] = mk(1, 16'hFFFE, 0, 0, 16'd0, 1, 1, 0, 8'd2);
    tbl[16] = mk(0, 16'h0000, 0, 1, 16'd0, 0, 1, 0, 8'd0);

    g1 = '{16'h0, 16'h1, 16'h3, 16'h2, 16'h6, 16'h7, 16'h5, 16'h4, 16'hC,
           16'hD, 16'hF, 16'hE, 16'hA, 16'hB, 16'h9, 16'h8, 16'h0};

    checks = 0;
    errors = 0;
    ifc.gray_valid = 1'b0;
    ifc.gray_in    = '0;
    ifc.num_bits   = 4'd3;
    ifc.clear_err  = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Lock and track across the full 4-bit range including wrap
    for (int i = 0; i < 17; i++)
      step(mk(1, g1[i], 3, 0, 16'(i % 16), 1, (i > 0), 0, 8'd0));

    // Break/relock, masking, W=1 and clear without a sample
    do_reset();
    for (int i = 0; i < 17; i++) step(tbl[i]);

    // Saturation via duplicate codes while locked, then clear against a break
    do_reset();
    step(mk(1, 16'h0000, 15, 0, 16'd0, 1, 0, 0, 8'd0));
    step(mk(1, 16'h0001, 15, 0, 16'd1, 1, 1, 0, 8'd0));
    v = 16'd1;
    for (int k = 1; k <= 300; k++) begin
      sat = (k > 255) ? 8'hFF : 8'(k);
      step(mk(1, g_of(v), 15, 0, v, 1, 0, 1, sat));
      v = v + 16'd1;
      step(mk(1, g_of(v), 15, 0, v, 1, 1, 0, sat));
    end
    step(mk(1, g_of(v), 15, 1, v, 1, 0, 1, 8'd0));

    // Width change while locked, then asynchronous reset mid-stream
    do_reset();
    step(mk(1, 16'h0000, 3, 0, 16'd0, 1, 0, 0, 8'd0));
    step(mk(1, 16'h0001, 3, 0, 16'd1, 1, 1, 0, 8'd0));
    step(mk(1, 16'h0003, 7, 0, 16'd2, 1, 0, 0, 8'd0));
    step(mk(1, 16'h0002, 7, 0, 16'd3, 1, 1, 0, 8'd0));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    ifc.gray_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step(mk(1, 16'h0005, 7, 0, 16'd6, 1, 0, 0, 8'd0));
    step(mk(1, 16'h0004, 7, 0, 16'd7, 1, 1, 0, 8'd0));

    @(negedge clk);
    ifc.gray_valid = 1'b0;
    ifc.clear_err  = 1'b0;
    @(posedge clk);
    #2;
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_sequence_checker.md
GRAY_SEQUENCE_CHECKER -- requirements
Module: gray_sequence_checker

Interface
REQ-001 The module SHALL have no parameters; the maximum code width is fixed at 16 bits.
REQ-002 Port clk  input  1  rising-edge clock.
REQ-003 Port rst  input  1  reset, asynchronous, active-high; clock clk.
REQ-004 Port gray_valid  input  1  gray_in carries a code this cycle.
REQ-005 Port gray_in  input  16  incoming Gray code word.
REQ-006 Port num_bits  input  4  active width selector; W = num_bits + 1 (range 1..16).
REQ-007 Port clear_err  input  1  synchronous clear of err_count.
REQ-008 Port bin_out  output  16  decoded binary value of the last accepted code.
REQ-009 Port bin_valid  output  1  one-cycle pulse: bin_out updated.
REQ-010 Port locked  output  1  checker is tracking a valid ascending sequence.
REQ-011 Port seq_err  output  1  one-cycle pulse: sequence break detected.
REQ-012 Port err_count  output  8  saturating count of sequence breaks.

Function
REQ-013 Decode SHALL be bin[i] = XOR of gray_in[W-1:i] for i < W; bits W..15 of gray_in are ignored and bin_out[15:W] SHALL read 0.
REQ-014 Latency SHALL be exactly 1 cycle: a sample with gray_valid=1 at edge N gives bin_out/bin_valid/seq_err at edge N+1. Cycles with gray_valid=0 leave bin_out, state and prev unchanged and drive bin_valid=0 and seq_err=0.
REQ-015 The FSM SHALL have three states: UNLOCKED, LOCKING and LOCKED. The locked output SHALL be 1 only in LOCKED.
REQ-016 In UNLOCKED, the first valid sample SHALL be stored as prev (binary) and the FSM SHALL go to LOCKING; no error is flagged.
REQ-017 In LOCKING, a valid sample equal to (prev+1) mod 2^W SHALL move the FSM to LOCKED; any other sample SHALL keep LOCKING with no error. prev is always updated.
REQ-018 In LOCKED, a valid sample equal to (prev+1) mod 2^W is accepted and the FSM stays in LOCKED.
REQ-019 In LOCKED, any other sample SHALL pulse seq_err, increment err_count, move the FSM to LOCKING and update prev. A repeated code counts as a break.
REQ-020 Wrap-around from 2^W-1 to 0 SHALL be accepted as a valid increment.
REQ-021 err_count SHALL saturate at 255. If clear_err coincides with an increment, the clear SHALL win and the result is 0.
REQ-022 num_bits SHALL be registered internally. When a sample arrives with a num_bits value different from the registered value, the FSM SHALL go to UNLOCKED and then treat that sample as the UNLOCKED first sample, with no error; it is still decoded and bin_valid pulses.
REQ-023 With W=1, the valid sequence SHALL be 0,1,0,1,... and the same rules apply.

Reset
REQ-024 While rst=1, the outputs SHALL be: bin_out=0, bin_valid=0, locked=0, seq_err=0, err_count=0; the FSM=UNLOCKED, prev=0 and the registered num_bits=15.
REQ-025 Reset asserted mid-sequence SHALL discard lock state and prev immediately. The first valid sample after release is handled as in UNLOCKED.

Verification
REQ-026 Lock and track, num_bits=3: feed Gray 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0.
  - Required response: bin_out follows 0..15 then 0, one cycle late.
  - locked=1 from the second bin_valid onward.
  - seq_err never pulses; err_count stays 0.
REQ-027 Break, num_bits=3, locked: feed Gray 0,1,3,7,5.
  - Required response: bin 0,1,2,5,6.
  - seq_err pulses once with bin 5; locked drops to 0 for that cycle.
  - bin 6 relocks the checker; err_count=1.
REQ-028 Masking, num_bits=1: feed gray_in 0xFFF2 then 0x0003.
  - Required response: bin_out=0x0003 then 0x0002.
  - Not ascending, so the FSM stays in LOCKING.
REQ-029 Saturation and clear: force 300 breaks, each using alternating duplicate codes while locked.
  - err_count SHALL hold at 255.
  - Assert clear_err in the same cycle as another break; err_count=0 on the next edge.
REQ-030 Width change and reset: while LOCKED at num_bits=3, change num_bits to 7 with the next sample.
  - Required response: locked=0 and no seq_err.
  - Assert rst mid-stream: all outputs 0 on the same cycle, asynchronously.
  - After release, the first valid sample produces no error.
